// File: rtl/channel_word_assembler.sv
// rtl/channel_word_assembler.sv - serial-to-parallel assembler for eight channel words with hold-deferred atomic publish
// Shadows fill LSB first during SHIFT; all eight words are copied out together once hold is low.
module channel_word_assembler #(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = 50
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [NUM_CH-1:0] trigger_channel_mask,
  input  logic [NUM_CH-1:0] ch_din,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  ch0,
  output logic [WIDTH-1:0]  ch1,
  output logic [WIDTH-1:0]  ch2,
  output logic [WIDTH-1:0]  ch3,
  output logic [WIDTH-1:0]  ch4,
  output logic [WIDTH-1:0]  ch5,
  output logic [WIDTH-1:0]  ch6,
  output logic [WIDTH-1:0]  ch7
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_PUBLISH = 2'd2
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [NUM_CH-1:0] mask_q;
  logic [WIDTH-1:0]  shadow_q [NUM_CH];
  logic [WIDTH-1:0]  shadow_d [NUM_CH];
  logic [WIDTH-1:0]  ch_q     [NUM_CH];
  logic              busy_q;
  logic              done_q;

  // Masked-off channels shift in nothing, so their shadow stays at the zero set on start.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      shadow_d[c] = '0;
      if (mask_q[c]) begin
        shadow_d[c] = {ch_din[c], shadow_q[c][WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow_q[c] <= '0;
        ch_q[c]     <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            mask_q  <= trigger_channel_mask;
            busy_q  <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
              shadow_q[c] <= '0;
            end
          end
        end
        ST_SHIFT: begin
          for (int c = 0; c < NUM_CH; c++) begin
            shadow_q[c] <= shadow_d[c];
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= ST_PUBLISH;
          end
        end
        ST_PUBLISH: begin
          if (!hold) begin
            for (int c = 0; c < NUM_CH; c++) begin
              ch_q[c] <= shadow_q[c];
            end
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ch0  = ch_q[0];
  assign ch1  = ch_q[1];
  assign ch2  = ch_q[2];
  assign ch3  = ch_q[3];
  assign ch4  = ch_q[4];
  assign ch5  = ch_q[5];
  assign ch6  = ch_q[6];
  assign ch7  = ch_q[7];

endmodule
